// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              src_d_q;
  logic              we_q;
  logic              pick_d;
  logic              pick_if;

  // Arbitration: D has priority unless IF has been passed over STARVE_LIMIT times in a row
  always_comb begin
    pick_d  = d_req && !(if_req && (starve_cnt == SC_W'(STARVE_LIMIT)));
    pick_if = if_req && !pick_d;
  end

  // Grants are offered only in IDLE and are forced low while reset is asserted
  assign d_gnt  = rst_n && (state == IDLE) && pick_d;
  assign if_gnt = rst_n && (state == IDLE) && pick_if;

  // Transfer sequencer: latches the winner, drives the memory pins and returns the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      src_d_q    <= 1'b0;
      we_q       <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d || pick_if) begin
            src_d_q   <= pick_d;
            we_q      <= pick_d && d_we;
            MemRead   <= !(pick_d && d_we);
            MemWrite  <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= (pick_d && d_we) ? d_wdata : '0;
            cnt       <= CNT_W'(MEM_LATENCY - 1);
            state     <= ACCESS;
            if (pick_d) begin
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            state    <= RESP;
            if (src_d_q) begin
              d_rvalid <= 1'b1;
              d_rdata  <= we_q ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transfer-level reference model
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // main instance, MEM_LATENCY=1
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:63] = '{default: '0};

  // second instance, MEM_LATENCY=3
  logic        if3_req = 1'b0, d3_req = 1'b0, d3_we = 1'b0;
  logic [31:0] if3_addr = '0, d3_addr = '0, d3_wdata = '0;
  logic        if3_gnt, if3_rvalid, d3_gnt, d3_rvalid, mem3_read, mem3_write;
  logic [31:0] if3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .MemRead(mem_read), .MemWrite(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(STARVE)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt), .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .MemRead(mem3_read), .MemWrite(mem3_write), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
    .mem_rdata(mem3_rdata)
  );

  // memory behind the main instance: combinational read, write on rising edge
  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  // ROM behind the latency-3 instance: word value derived from the address
  assign mem3_rdata = mem3_read ? {16'hA5A5, mem3_addr[15:0]} : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: a transfer is "age" cycles old; 0 = no transfer in flight
  int          age = 0;
  int          d_streak = 0;
  logic        m_src_d = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_d_rd = '0;
  logic [31:0] shadow [0:63] = '{default: '0};
  int          wr_cnt = 0;

  always @(negedge clk) begin
    logic e_ig, e_dg, e_mr, e_mw, e_ir, e_dr, pd, pi;
    if (mem_write) wr_cnt++;
    if (!rst_n) begin
      age = 0; d_streak = 0; m_if_rd = '0; m_d_rd = '0;
      chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_memread", mem_read, 0);  chk("rst_memwrite", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
    end else begin
      e_ig = 0; e_dg = 0; e_mr = 0; e_mw = 0; e_ir = 0; e_dr = 0;
      pd = 0; pi = 0;
      if (age == 0) begin
        pd = d_req && !(if_req && d_streak == STARVE);
        pi = if_req && !pd;
        e_dg = pd; e_ig = pi;
      end else if (age == 1) begin
        e_mr = !m_we; e_mw = m_we;
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end else begin
        e_dr = m_src_d; e_ir = !m_src_d;
      end
      chk("if_gnt", if_gnt, e_ig);       chk("d_gnt", d_gnt, e_dg);
      chk("memread", mem_read, e_mr);    chk("memwrite", mem_write, e_mw);
      chk("if_rvalid", if_rvalid, e_ir); chk("d_rvalid", d_rvalid, e_dr);
      chk("if_rdata", if_rdata, m_if_rd); chk("d_rdata", d_rdata, m_d_rd);
      // advance to the next cycle
      if (age == 0) begin
        if (pd || pi) begin
          age = 1; m_src_d = pd; m_we = pd && d_we;
          m_addr = pd ? d_addr : if_addr; m_wdata = d_wdata;
          if (pd) d_streak = if_req ? ((d_streak < STARVE) ? d_streak + 1 : STARVE) : 0;
          else d_streak = 0;
        end
      end else if (age == 1) begin
        age = 2;
        if (m_we) begin
          shadow[m_addr[7:2]] = m_wdata;
          m_d_rd = '0;
        end else if (m_src_d) m_d_rd = shadow[m_addr[7:2]];
        else m_if_rd = shadow[m_addr[7:2]];
      end else begin
        age = 0;
      end
    end
  end

  task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] w,
                      output int gcyc, output int rcyc, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_addr = a; d_wdata = w;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (d_gnt) break;
      n++;
      if (n > 20) begin chk("d_gnt_timeout", 1, 0); break; end
    end
    gcyc = cyc;
    @(posedge clk); #1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (d_rvalid) break;
      n++;
      if (n > 20) begin chk("d_rvalid_timeout", 1, 0); break; end
    end
    rcyc = cyc; rd = d_rdata;
  endtask

  task automatic if_op(input logic [31:0] a, output int gcyc, output int rcyc, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    if_req = 1; if_addr = a;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (if_gnt) break;
      n++;
      if (n > 20) begin chk("if_gnt_timeout", 1, 0); break; end
    end
    gcyc = cyc;
    @(posedge clk); #1;
    if_req = 0; if_addr = '0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (if_rvalid) break;
      n++;
      if (n > 20) begin chk("if_rvalid_timeout", 1, 0); break; end
    end
    rcyc = cyc; rd = if_rdata;
  endtask

  initial begin
    int g, r, n, nr, w0, act;
    logic [31:0] rd;
    string order;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_memread", mem_read, 0);
    chk("reset_d_rdata", d_rdata, 0);

    // 1: store then load at address 0
    w0 = wr_cnt;
    d_op(1, 32'h0, 32'hDEADBEEF, g, r, rd);
    chk("t1_store_rdata_zero", rd, 32'h0);
    chk("t1_memwrite_cycles", wr_cnt - w0, 1);
    chk("t1_store_latency", r - g, 2);
    d_op(0, 32'h0, 32'h0, g, r, rd);
    chk("t1_load_data", rd, 32'hDEADBEEF);
    d_op(1, 32'h8, 32'h11111111, g, r, rd);

    // 2: store at 4, then fetch at 4
    d_op(1, 32'h4, 32'h12345678, g, r, rd);
    if_op(32'h4, g, r, rd);
    chk("t2_if_latency", r - g, 2);
    chk("t2_if_data", rd, 32'h12345678);
    chk("t2_d_rdata_held", d_rdata, 32'h0);

    // 3: both requesters held high, grant order bounded by starvation limit
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h0; if_req = 1; if_addr = 32'h4;
    order = ""; n = 0;
    while (order.len() < 10 && n < 80) begin
      @(negedge clk);
      if (d_gnt) order = {order, "D"};
      if (if_gnt) order = {order, "I"};
      n++;
    end
    @(posedge clk); #1;
    d_req = 0; if_req = 0; d_addr = '0; if_addr = '0;
    act = (order == "DDDDIDDDDI") ? 1 : 0;
    if (act == 0) $display("grant order seen: %s", order);
    chk("t3_grant_order", act, 1);
    repeat (4) @(negedge clk);
    chk("t3_if_rdata", if_rdata, 32'h12345678);
    chk("t3_d_rdata", d_rdata, 32'hDEADBEEF);

    // 4: latency-3 instance load
    @(posedge clk); #1;
    d3_req = 1; d3_we = 0; d3_addr = 32'h10;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (d3_gnt) break;
      n++;
      if (n > 20) begin chk("t4_gnt_timeout", 1, 0); break; end
    end
    g = cyc;
    @(posedge clk); #1;
    d3_req = 0; d3_addr = '0;
    nr = 0; n = 0;
    while (1) begin
      @(negedge clk);
      if (mem3_read) nr++;
      if (d3_rvalid) break;
      n++;
      if (n > 20) begin chk("t4_rvalid_timeout", 1, 0); break; end
    end
    chk("t4_memread_cycles", nr, 3);
    chk("t4_rvalid_delay", cyc - g, 4);
    chk("t4_memread_in_resp", mem3_read, 0);
    chk("t4_rdata", d3_rdata, 32'hA5A50010);

    // 5: reset asserted during a store's access phase
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hCAFEBABE;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (d_gnt) break;
      n++;
      if (n > 20) begin chk("t5_gnt_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    chk("t5_memwrite_before", mem_write, 1);
    #1 rst_n = 0;
    #1 chk("t5_memwrite_async", mem_write, 0);
    nr = 0;
    repeat (3) begin @(negedge clk); if (d_rvalid) nr++; end
    @(posedge clk); #1 rst_n = 1;
    repeat (4) begin @(negedge clk); if (d_rvalid) nr++; end
    chk("t5_no_rvalid", nr, 0);
    chk("t5_mem8_kept", mem[2], 32'h11111111);

    // 6: idle for 10 cycles
    nr = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_gnt || d_gnt || if_rvalid || d_rvalid || mem_read || mem_write) nr++;
    end
    chk("t6_idle_quiet", nr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
